tlb_op_ctrl: RTL and testbench
==============================

TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have ports (name direction width meaning): clk in 1 system clock; resetn in 1 asynchronous active-low reset.
REQ-002 SHALL have ports: op_valid in 1 TLB instruction request; op_ready out 1 request accepted when high; op_code in 3 0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV, others reserved.
REQ-003 SHALL have ports: inv_op in 5 INVTLB op field; inv_asid in 10; inv_vppn in 19; busy out 1 op in progress; done out 1 one-cycle completion pulse; inv_ine out 1 one-cycle illegal-INVTLB pulse.
REQ-004 SHALL have ports: csr_asid in 10; csr_tlbidx_index in 4; csr_tlbehi_vppn in 19; mmu_vppn in 19 and mmu_asid in 10 from the data MMU lookup.
REQ-005 SHALL have TLB ports: s_vppn out 19; s_asid out 10; s_found in 1; s_index in 4; r_index out 4; r_e in 1; r_g in 1; r_asid in 10; r_vppn in 19 (combinational read); we out 1; w_index out 4; w_inv out 1 (1: clear E only, 0: write CSR-supplied entry).
REQ-006 SHALL have result ports: srch_found out 1; srch_index out 4; rd_valid out 1 one-cycle CSR capture strobe for TLBRD.

Function
REQ-007 SHALL implement FSM states IDLE, SRCH, RD, WR, FILL, INV, DONE; op_ready = (state==IDLE); busy = (state!=IDLE).
REQ-008 SHALL, on op_valid&&op_ready in cycle T, latch op_code, inv_op, inv_asid, inv_vppn and enter the op state at T+1; reserved op_code SHALL go to DONE with no side effects.
REQ-009 SHALL, in SRCH, drive s_vppn=csr_tlbehi_vppn, s_asid=csr_asid and register s_found/s_index into srch_found/srch_index at the end of that cycle; results SHALL hold until the next SRCH.
REQ-010 SHALL, outside SRCH, pass mmu_vppn/mmu_asid through to s_vppn/s_asid (data MMU owns search port).
REQ-011 SHALL, in RD, drive r_index=csr_tlbidx_index and rd_valid=1 for that one cycle.
REQ-012 SHALL, in WR, assert we=1, w_inv=0, w_index=csr_tlbidx_index for one cycle.
REQ-013 SHALL, in FILL, assert we=1, w_inv=0, w_index=current random index for one cycle.
REQ-014 SHALL, in INV, walk a 4-bit counter 0..15, one entry per cycle, r_index=counter; when r_e=1 and entry matches, assert we=1, w_inv=1, w_index=counter in the same cycle.
REQ-015 Match rules: op 0,1 all; 2 g=1; 3 g=0; 4 g=0&&asid==inv_asid; 5 g=0&&asid==inv_asid&&vppn==inv_vppn; 6 (g=1||asid==inv_asid)&&vppn==inv_vppn; vppn compares all 19 bits.
REQ-016 SHALL, for inv_op>6, skip INV, pulse inv_ine at T+1, go to DONE, perform no writes.
REQ-017 SHALL leave INV after counter=15 to DONE; DONE lasts one cycle with done=1, then IDLE.
REQ-018 Latency: SRCH/RD/WR/FILL done at T+2; INV done at T+17; illegal INV done at T+2; next op acceptable at T+3 / T+18.
REQ-019 SHALL keep a random index register advancing every clock regardless of state.
REQ-020 we, rd_valid, done, inv_ine SHALL never be high in IDLE.

Reset
REQ-021 SHALL, on resetn low (asynchronous, any state including mid-INV), force IDLE, counter 0, random 4'b0001 (LFSR) or 0 (counter), srch_found 0, srch_index 0, all strobes 0; entries already invalidated stay invalidated.

Configuration
REQ-022 SHALL, with TLB_FILL_LFSR_EN defined, generate the random index as a 4-bit LFSR x^4+x^3+1 (period 15, never 0); without it, a 4-bit free-running counter incrementing by 1 modulo 16.

Verification
REQ-023 Reset release, op_valid=1 op_code=3 at first edge (counter build) -> we=1, w_index=1 at T+1, done at T+2.
REQ-024 SRCH with csr_tlbehi_vppn matching entry 9 -> srch_found=1, srch_index=9 at T+2; mmu_vppn back on s_vppn at T+2.
REQ-025 INV op=5 with entries 3 (g=0, asid match, vppn match) and 7 (g=1, same vppn) -> only entry 3 written w_inv=1; done at T+17.
REQ-026 INV op=7 -> inv_ine pulse at T+1, no we, done at T+2.
REQ-027 resetn low during INV at counter=5 -> immediate IDLE, busy=0, no further writes; new op accepted at first edge after release.
REQ-028 Back-to-back WR then RD with op_valid held -> second accepted at T+3, we at T+1, rd_valid at T+4.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB.
// Define TLB_FILL_LFSR_EN to use an LFSR for the TLBFILL index (default: free-running counter).
module tlb_op_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_code,
  input  logic [4:0]  inv_op,
  input  logic [9:0]  inv_asid,
  input  logic [18:0] inv_vppn,
  output logic        busy,
  output logic        done,
  output logic        inv_ine,
  input  logic [9:0]  csr_asid,
  input  logic [3:0]  csr_tlbidx_index,
  input  logic [18:0] csr_tlbehi_vppn,
  input  logic [18:0] mmu_vppn,
  input  logic [9:0]  mmu_asid,
  output logic [18:0] s_vppn,
  output logic [9:0]  s_asid,
  input  logic        s_found,
  input  logic [3:0]  s_index,
  output logic [3:0]  r_index,
  input  logic        r_e,
  input  logic        r_g,
  input  logic [9:0]  r_asid,
  input  logic [18:0] r_vppn,
  output logic        we,
  output logic [3:0]  w_index,
  output logic        w_inv,
  output logic        srch_found,
  output logic [3:0]  srch_index,
  output logic        rd_valid
);

  localparam int unsigned IDX_W   = 4;
  localparam int unsigned ASID_W  = 10;
  localparam int unsigned VPPN_W  = 19;
  localparam int unsigned INVOP_W = 5;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  localparam logic [IDX_W-1:0]   IDX_LAST   = '1;
  localparam logic [INVOP_W-1:0] INVOP_LAST = INVOP_W'(6);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRCH,
    ST_RD,
    ST_WR,
    ST_FILL,
    ST_INV,
    ST_DONE
  } state_t;

  state_t              state;
  logic [INVOP_W-1:0]  inv_op_q;
  logic [ASID_W-1:0]   inv_asid_q;
  logic [VPPN_W-1:0]   inv_vppn_q;
  logic [IDX_W-1:0]    cnt;
  logic [IDX_W-1:0]    rnd;
  logic                inv_illegal;
  logic                asid_hit;
  logic                vppn_hit;
  logic                entry_match;

  assign inv_illegal = (inv_op_q > INVOP_LAST);

  // INVTLB entry selection for the entry currently on the read port
  always_comb begin
    asid_hit    = (r_asid == inv_asid_q);
    vppn_hit    = (r_vppn == inv_vppn_q);
    entry_match = 1'b0;
    case (inv_op_q)
      INVOP_W'(0), INVOP_W'(1): entry_match = 1'b1;
      INVOP_W'(2):              entry_match = r_g;
      INVOP_W'(3):              entry_match = !r_g;
      INVOP_W'(4):              entry_match = !r_g && asid_hit;
      INVOP_W'(5):              entry_match = !r_g && asid_hit && vppn_hit;
      INVOP_W'(6):              entry_match = (r_g || asid_hit) && vppn_hit;
      default:                  entry_match = 1'b0;
    endcase
  end

  // Sequencer state, latched operands, INV walk counter and search results
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vppn_q <= '0;
      cnt        <= '0;
      srch_found <= 1'b0;
      srch_index <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            inv_op_q   <= inv_op;
            inv_asid_q <= inv_asid;
            inv_vppn_q <= inv_vppn;
            cnt        <= '0;
            case (op_code)
              OP_SRCH: state <= ST_SRCH;
              OP_RD:   state <= ST_RD;
              OP_WR:   state <= ST_WR;
              OP_FILL: state <= ST_FILL;
              OP_INV:  state <= ST_INV;
              default: state <= ST_DONE;
            endcase
          end
        end
        ST_SRCH: begin
          srch_found <= s_found;
          srch_index <= s_index;
          state      <= ST_DONE;
        end
        ST_RD, ST_WR, ST_FILL: state <= ST_DONE;
        ST_INV: begin
          if (inv_illegal || (cnt == IDX_LAST)) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Replacement index for TLBFILL, advancing every clock
`ifdef TLB_FILL_LFSR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rnd <= IDX_W'(1);
    end else begin
      rnd <= {rnd[2:0], rnd[3] ^ rnd[2]};
    end
  end
`else
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rnd <= '0;
    end else begin
      rnd <= rnd + IDX_W'(1);
    end
  end
`endif

  // Port steering decoded from the registered state
  always_comb begin
    op_ready = (state == ST_IDLE);
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
    rd_valid = (state == ST_RD);
    inv_ine  = (state == ST_INV) && inv_illegal;
    s_vppn   = mmu_vppn;
    s_asid   = mmu_asid;
    r_index  = csr_tlbidx_index;
    we       = 1'b0;
    w_inv    = 1'b0;
    w_index  = '0;
    case (state)
      ST_SRCH: begin
        s_vppn = csr_tlbehi_vppn;
        s_asid = csr_asid;
      end
      ST_WR: begin
        we      = 1'b1;
        w_index = csr_tlbidx_index;
      end
      ST_FILL: begin
        we      = 1'b1;
        w_index = rnd;
      end
      ST_INV: begin
        r_index = cnt;
        w_index = cnt;
        w_inv   = !inv_illegal;
        we      = !inv_illegal && r_e && entry_match;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: a 16-entry TLB model plus a per-cycle expected-output timeline.
module tb_tlb_op_ctrl;

  localparam int NCYC = 4096;

  logic        clk;
  logic        resetn;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vppn;
  logic        busy;
  logic        done;
  logic        inv_ine;
  logic [9:0]  csr_asid;
  logic [3:0]  csr_tlbidx_index;
  logic [18:0] csr_tlbehi_vppn;
  logic [18:0] mmu_vppn;
  logic [9:0]  mmu_asid;
  logic [18:0] s_vppn;
  logic [9:0]  s_asid;
  logic        s_found;
  logic [3:0]  s_index;
  logic [3:0]  r_index;
  logic        r_e;
  logic        r_g;
  logic [9:0]  r_asid;
  logic [18:0] r_vppn;
  logic        we;
  logic [3:0]  w_index;
  logic        w_inv;
  logic        srch_found;
  logic [3:0]  srch_index;
  logic        rd_valid;

  tlb_op_ctrl dut (
    .clk(clk), .resetn(resetn),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .busy(busy), .done(done), .inv_ine(inv_ine),
    .csr_asid(csr_asid), .csr_tlbidx_index(csr_tlbidx_index),
    .csr_tlbehi_vppn(csr_tlbehi_vppn),
    .mmu_vppn(mmu_vppn), .mmu_asid(mmu_asid),
    .s_vppn(s_vppn), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
    .r_index(r_index), .r_e(r_e), .r_g(r_g), .r_asid(r_asid), .r_vppn(r_vppn),
    .we(we), .w_index(w_index), .w_inv(w_inv),
    .srch_found(srch_found), .srch_index(srch_index), .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // TLB storage and the CSR-supplied entry written by WR/FILL
  bit        te [16];
  bit        tg [16];
  bit [9:0]  tasid [16];
  bit [18:0] tvppn [16];
  bit        wr_g;
  bit [9:0]  wr_asid;
  bit [18:0] wr_vppn;

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 16; i++) begin
        te[i] <= 1'b0; tg[i] <= 1'b0; tasid[i] <= '0; tvppn[i] <= '0;
      end
      te[9]  <= 1'b1; tg[9]  <= 1'b0; tasid[9]  <= 10'h005; tvppn[9]  <= 19'h1234A;
      te[3]  <= 1'b1; tg[3]  <= 1'b0; tasid[3]  <= 10'h02A; tvppn[3]  <= 19'h7ABCD;
      te[7]  <= 1'b1; tg[7]  <= 1'b1; tasid[7]  <= 10'h011; tvppn[7]  <= 19'h7ABCD;
      te[12] <= 1'b1; tg[12] <= 1'b0; tasid[12] <= 10'h02A; tvppn[12] <= 19'h00001;
    end else if (resetn && we) begin
      if (w_inv) begin
        te[w_index] <= 1'b0;
      end else begin
        te[w_index] <= 1'b1; tg[w_index] <= wr_g;
        tasid[w_index] <= wr_asid; tvppn[w_index] <= wr_vppn;
      end
    end
  end

  assign r_e    = te[r_index];
  assign r_g    = tg[r_index];
  assign r_asid = tasid[r_index];
  assign r_vppn = tvppn[r_index];

  always_comb begin
    s_found = 1'b0;
    s_index = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (te[i] && tvppn[i] == s_vppn && (tg[i] || tasid[i] == s_asid)) begin
        s_found = 1'b1;
        s_index = 4'(i);
      end
    end
  end

  // Expected-output timeline, indexed by cycle number
  bit       ex_busy [NCYC];
  bit       ex_done [NCYC];
  bit       ex_ine  [NCYC];
  bit       ex_rdv  [NCYC];
  bit       ex_we   [NCYC];
  bit [3:0] ex_widx [NCYC];
  bit       ex_winv [NCYC];
  bit       ex_rchk [NCYC];
  bit [3:0] ex_ridx [NCYC];
  bit       ex_srch [NCYC];
  bit       ex_sfset[NCYC];
  bit       ex_sf   [NCYC];
  bit [3:0] ex_si   [NCYC];
  int       idle_at;
  int       rel_cyc;
  bit       cur_sf;
  bit [3:0] cur_si;

  int n_cmp;
  int n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit [3:0] rnd_at(input int c);
    int n;
    bit [3:0] v;
    n = c - rel_cyc;
`ifdef TLB_FILL_LFSR_EN
    v = 4'b0001;
    for (int i = 0; i < n % 15; i++) v = {v[2:0], v[3] ^ v[2]};
`else
    v = 4'(n);
`endif
    return v;
  endfunction

  function automatic bit [4:0] search_ref(input bit [18:0] v, input bit [9:0] a);
    for (int i = 0; i < 16; i++)
      if (te[i] && tvppn[i] == v && (tg[i] || tasid[i] == a)) return {1'b1, 4'(i)};
    return 5'd0;
  endfunction

  function automatic bit inv_hit(input int k, input bit [4:0] iop, input bit [9:0] ia, input bit [18:0] iv);
    bit am, vm;
    am = (tasid[k] == ia);
    vm = (tvppn[k] == iv);
    if (!te[k]) return 1'b0;
    case (iop)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return tg[k];
      5'd3:       return !tg[k];
      5'd4:       return !tg[k] && am;
      5'd5:       return !tg[k] && am && vm;
      5'd6:       return (tg[k] || am) && vm;
      default:    return 1'b0;
    endcase
  endfunction

  // Fill in what the outputs must be for an op accepted in cycle t
  task automatic plan(input bit [2:0] op, input bit [4:0] iop, input bit [9:0] ia, input bit [18:0] iv, input int t);
    bit [4:0] sr;
    if (t + 20 >= NCYC) begin
      $display("FAIL plan_range: cycle %0d beyond table", t);
      $fatal(1);
    end
    case (op)
      3'd0: begin
        sr = search_ref(csr_tlbehi_vppn, csr_asid);
        ex_busy[t+1] = 1; ex_srch[t+1] = 1;
        ex_busy[t+2] = 1; ex_done[t+2] = 1;
        ex_sfset[t+2] = 1; ex_sf[t+2] = sr[4]; ex_si[t+2] = sr[3:0];
        idle_at = t + 3;
      end
      3'd1: begin
        ex_busy[t+1] = 1; ex_rdv[t+1] = 1; ex_rchk[t+1] = 1; ex_ridx[t+1] = csr_tlbidx_index;
        ex_busy[t+2] = 1; ex_done[t+2] = 1;
        idle_at = t + 3;
      end
      3'd2, 3'd3: begin
        ex_busy[t+1] = 1; ex_we[t+1] = 1; ex_winv[t+1] = 0;
        ex_widx[t+1] = (op == 3'd2) ? csr_tlbidx_index : rnd_at(t + 1);
        ex_busy[t+2] = 1; ex_done[t+2] = 1;
        idle_at = t + 3;
      end
      3'd4: begin
        if (iop > 5'd6) begin
          ex_busy[t+1] = 1; ex_ine[t+1] = 1;
          ex_busy[t+2] = 1; ex_done[t+2] = 1;
          idle_at = t + 3;
        end else begin
          for (int k = 0; k < 16; k++) begin
            ex_busy[t+1+k] = 1; ex_rchk[t+1+k] = 1; ex_ridx[t+1+k] = 4'(k);
            ex_we[t+1+k] = inv_hit(k, iop, ia, iv); ex_winv[t+1+k] = 1; ex_widx[t+1+k] = 4'(k);
          end
          ex_busy[t+17] = 1; ex_done[t+17] = 1;
          idle_at = t + 18;
        end
      end
      default: begin
        ex_busy[t+1] = 1; ex_done[t+1] = 1;
        idle_at = t + 2;
      end
    endcase
  endtask

  task automatic reset_model(input int c);
    for (int i = c; i < NCYC; i++) begin
      ex_busy[i] = 0; ex_done[i] = 0; ex_ine[i] = 0; ex_rdv[i] = 0; ex_we[i] = 0;
      ex_widx[i] = 0; ex_winv[i] = 0; ex_rchk[i] = 0; ex_ridx[i] = 0; ex_srch[i] = 0;
      ex_sfset[i] = 0; ex_sf[i] = 0; ex_si[i] = 0;
    end
    ex_sfset[c] = 1;
    idle_at = 0;
  endtask

  // Per-cycle comparison against the timeline
  always @(negedge clk) begin
    if (cyc < NCYC) begin
      if (ex_sfset[cyc]) begin
        cur_sf = ex_sf[cyc];
        cur_si = ex_si[cyc];
      end
      chk("busy", 32'(busy), 32'(ex_busy[cyc]));
      chk("op_ready", 32'(op_ready), 32'(!ex_busy[cyc]));
      chk("done", 32'(done), 32'(ex_done[cyc]));
      chk("inv_ine", 32'(inv_ine), 32'(ex_ine[cyc]));
      chk("rd_valid", 32'(rd_valid), 32'(ex_rdv[cyc]));
      chk("we", 32'(we), 32'(ex_we[cyc]));
      if (ex_we[cyc]) begin
        chk("w_index", 32'(w_index), 32'(ex_widx[cyc]));
        chk("w_inv", 32'(w_inv), 32'(ex_winv[cyc]));
      end
      if (ex_rchk[cyc]) chk("r_index", 32'(r_index), 32'(ex_ridx[cyc]));
      chk("s_vppn", 32'(s_vppn), 32'(ex_srch[cyc] ? csr_tlbehi_vppn : mmu_vppn));
      chk("s_asid", 32'(s_asid), 32'(ex_srch[cyc] ? csr_asid : mmu_asid));
      chk("srch_found", 32'(srch_found), 32'(cur_sf));
      chk("srch_index", 32'(srch_index), 32'(cur_si));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op and hold op_valid until the model says it is accepted; returns in cycle T+1
  task automatic issue(input bit [2:0] op, input bit [4:0] iop, input bit [9:0] ia, input bit [18:0] iv, output int t);
    op_valid = 1'b1; op_code = op; inv_op = iop; inv_asid = ia; inv_vppn = iv;
    while (cyc < idle_at) step();
    t = cyc;
    plan(op, iop, ia, iv, t);
    step();
  endtask

  task automatic drop();
    op_valid = 1'b0; op_code = 3'd0; inv_op = 5'd0; inv_asid = 10'd0; inv_vppn = 19'd0;
  endtask

  task automatic do_wr(input bit [3:0] idx, input bit g, input bit [9:0] a, input bit [18:0] v);
    int t;
    csr_tlbidx_index = idx; wr_g = g; wr_asid = a; wr_vppn = v;
    issue(3'd2, 5'd0, 10'd0, 19'd0, t);
    drop();
    step();
  endtask

  task automatic run_inv(input bit [4:0] iop, input bit [9:0] ia, input bit [18:0] iv);
    int t;
    issue(3'd4, iop, ia, iv, t);
    drop();
    repeat (17) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, t2, nw;
    logic [3:0] lw;
    resetn = 1'b0;
    drop();
    csr_asid = 10'h005; csr_tlbidx_index = 4'd0; csr_tlbehi_vppn = 19'h0;
    mmu_vppn = 19'h0F0F0; mmu_asid = 10'h0AA;
    wr_g = 0; wr_asid = 10'h100; wr_vppn = 19'h55555;
    idle_at = 0; rel_cyc = 0;
    ex_sfset[0] = 1;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(op_ready), 32'd1);
    chk("rst_srch_found", 32'(srch_found), 32'd0);

    // FILL presented on the first edge after reset release
    rel_cyc = cyc; resetn = 1'b1;
    issue(3'd3, 5'd0, 10'd0, 19'd0, t);
    chk("fill_we", 32'(we), 32'd1);
`ifdef TLB_FILL_LFSR_EN
    chk("fill_idx", 32'(w_index), 32'd2);
`else
    chk("fill_idx", 32'(w_index), 32'd1);
`endif
    drop(); step();
    chk("fill_done", 32'(done), 32'd1);

    // Search hit on entry 9, then the MMU regains the search port
    csr_tlbehi_vppn = 19'h1234A; csr_asid = 10'h005;
    issue(3'd0, 5'd0, 10'd0, 19'd0, t); drop();
    chk("srch_port", 32'(s_vppn), 32'h1234A);
    step();
    chk("srch_hit_found", 32'(srch_found), 32'd1);
    chk("srch_hit_index", 32'(srch_index), 32'd9);
    chk("srch_mmu_back", 32'(s_vppn), 32'h0F0F0);
    chk("srch_done", 32'(done), 32'd1);
    step();

    // Search miss
    csr_tlbehi_vppn = 19'h00BAD;
    issue(3'd0, 5'd0, 10'd0, 19'd0, t); drop(); step();
    chk("srch_miss_found", 32'(srch_found), 32'd0);
    step();

    // WR then RD back to back with op_valid held
    csr_tlbidx_index = 4'd4; wr_g = 0; wr_asid = 10'h100; wr_vppn = 19'h22222;
    issue(3'd2, 5'd0, 10'd0, 19'd0, t);
    chk("b2b_we", 32'(we), 32'd1);
    chk("b2b_widx", 32'(w_index), 32'd4);
    issue(3'd1, 5'd0, 10'd0, 19'd0, t2);
    drop();
    chk("b2b_rd_valid", 32'(rd_valid), 32'd1);
    chk("b2b_rd_index", 32'(r_index), 32'd4);
    chk("b2b_rd_e", 32'(r_e), 32'd1);
    step(); step();

    // INVTLB op 5: only entry 3 qualifies
    issue(3'd4, 5'd5, 10'h02A, 19'h7ABCD, t); drop();
    nw = 0; lw = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (we) begin nw++; lw = w_index; end
      step();
    end
    chk("inv5_done", 32'(done), 32'd1);
    chk("inv5_writes", 32'(nw), 32'd1);
    chk("inv5_index", 32'(lw), 32'd3);
    step();
    chk("inv5_e3", 32'(te[3]), 32'd0);
    chk("inv5_e7", 32'(te[7]), 32'd1);
    chk("inv5_e12", 32'(te[12]), 32'd1);

    // Illegal INVTLB op
    issue(3'd4, 5'd7, 10'd0, 19'd0, t); drop();
    chk("ine_pulse", 32'(inv_ine), 32'd1);
    chk("ine_no_we", 32'(we), 32'd0);
    step();
    chk("ine_done", 32'(done), 32'd1);
    step();

    run_inv(5'd2, 10'd0, 19'd0);
    step();
    chk("inv2_e7", 32'(te[7]), 32'd0);
    run_inv(5'd4, 10'h02A, 19'd0);
    step();
    chk("inv4_e12", 32'(te[12]), 32'd0);
    chk("inv4_e9", 32'(te[9]), 32'd1);

    // Reserved op code
    issue(3'd6, 5'd0, 10'd0, 19'd0, t); drop();
    chk("rsvd_done", 32'(done), 32'd1);
    step();

    repeat (3) step();
    issue(3'd3, 5'd0, 10'd0, 19'd0, t); drop(); step(); step();

    // INVTLB op 6: global or ASID match, plus VPPN match
    do_wr(4'd10, 1'b1, 10'h033, 19'h0ABCD);
    do_wr(4'd11, 1'b0, 10'h044, 19'h0ABCD);
    do_wr(4'd13, 1'b0, 10'h055, 19'h0ABCD);
    run_inv(5'd6, 10'h044, 19'h0ABCD);
    step();
    chk("inv6_e10", 32'(te[10]), 32'd0);
    chk("inv6_e11", 32'(te[11]), 32'd0);
    chk("inv6_e13", 32'(te[13]), 32'd1);

    csr_tlbehi_vppn = 19'h1234A; csr_asid = 10'h006;
    issue(3'd0, 5'd0, 10'd0, 19'd0, t); drop(); step(); step();

    // Reset in the middle of an INVTLB walk (counter at 5)
    issue(3'd4, 5'd0, 10'd0, 19'd0, t); drop();
    repeat (5) step();
    chk("walk_ridx5", 32'(r_index), 32'd5);
    resetn = 1'b0;
    reset_model(cyc);
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_we", 32'(we), 32'd0);
    step(); step();
    csr_tlbehi_vppn = 19'h1234A; csr_asid = 10'h005;
    rel_cyc = cyc; resetn = 1'b1;
    issue(3'd0, 5'd0, 10'd0, 19'd0, t); drop();
    chk("post_rst_accept", 32'(busy), 32'd1);
    step();
    chk("post_rst_found", 32'(srch_found), 32'd1);
    chk("post_rst_index", 32'(srch_index), 32'd9);
    step();
    chk("rst_e4_invalid", 32'(te[4]), 32'd0);
    chk("rst_e9_valid", 32'(te[9]), 32'd1);
    chk("rst_e13_valid", 32'(te[13]), 32'd1);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
